// File: rtl/spi_ctrl_pkg.sv
// Shared offsets, response codes and helpers for the SPI controller AXI4-Lite register block.
package spi_ctrl_pkg;

  localparam logic [2:0] OFS_CTRL    = 3'd0;
  localparam logic [2:0] OFS_CLKDIV  = 3'd1;
  localparam logic [2:0] OFS_TXDATA  = 3'd2;
  localparam logic [2:0] OFS_SCRATCH = 3'd3;
  localparam logic [2:0] OFS_STATUS  = 3'd4;
  localparam logic [2:0] OFS_RXDATA  = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Member order puts en at bit 0, cpol at bit 1, cpha at bit 2 of CTRL.
  typedef struct packed {
    logic cpha;
    logic cpol;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/spi_ctrl_regbank.sv
// Register storage, TX launch flag and sticky RX capture for the SPI controller.
// Byte-lane writes are honoured only when SPI_CTRL_WSTRB_EN is defined.
module spi_ctrl_regbank
  import spi_ctrl_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter logic [15:0] CLKDIV_RESET = 16'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_ofs,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        wr_strb,
  output logic              wr_slverr,
  input  logic              rd_rx_clr,
  input  logic              tx_ready,
  output logic              tx_valid,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic              rx_push,
  output logic [DATA_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] clkdiv_q,
  output logic [DATA_W-1:0] txdata_q,
  output logic [DATA_W-1:0] scratch_q,
  output logic [DATA_W-1:0] rxdata_q,
  output logic              rx_full
);

  logic [DATA_W-1:0] new_word;
  logic              launch_ok;
  logic              wr_ok;

`ifdef SPI_CTRL_WSTRB_EN
  logic [DATA_W-1:0] old_word;

  always_comb begin
    old_word = '0;
    case (wr_ofs)
      OFS_CTRL:    old_word = ctrl_q;
      OFS_CLKDIV:  old_word = clkdiv_q;
      OFS_TXDATA:  old_word = txdata_q;
      OFS_SCRATCH: old_word = scratch_q;
      default:     old_word = '0;
    endcase
  end

  assign new_word  = merge_wstrb(old_word, wr_data, wr_strb);
  assign launch_ok = |wr_strb;
`else
  logic unused_wstrb;

  assign new_word     = wr_data;
  assign launch_ok    = 1'b1;
  assign unused_wstrb = &{1'b0, wr_strb};
`endif

  // A pending TX word must not be overwritten; unmapped slots 6 and 7 error out.
  assign wr_slverr = (wr_ofs > OFS_RXDATA) || ((wr_ofs == OFS_TXDATA) && tx_valid);
  assign wr_ok     = wr_en && !wr_slverr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      clkdiv_q  <= {{(DATA_W-16){1'b0}}, CLKDIV_RESET};
      txdata_q  <= '0;
      scratch_q <= '0;
      rxdata_q  <= '0;
      tx_valid  <= 1'b0;
      rx_full   <= 1'b0;
    end else begin
      if (tx_valid && tx_ready)
        tx_valid <= 1'b0;
      if (wr_ok) begin
        case (wr_ofs)
          OFS_CTRL:    ctrl_q    <= new_word;
          OFS_CLKDIV:  clkdiv_q  <= new_word;
          OFS_TXDATA: begin
            txdata_q <= new_word;
            tx_valid <= launch_ok;
          end
          OFS_SCRATCH: scratch_q <= new_word;
          default: ;
        endcase
      end
      // A push landing on the read-clear cycle keeps the flag set.
      if (rx_push) begin
        rxdata_q <= rx_data_in;
        rx_full  <= 1'b1;
      end else if (rd_rx_clr) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_ctrl_axil_slave.sv
// AXI4-Lite responder for the SPI controller: write/read channel handling and read mux.
// Optional byte-lane write support is enabled with SPI_CTRL_WSTRB_EN.
module spi_ctrl_axil_slave
  import spi_ctrl_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [15:0] CLKDIV_RESET       = 16'd4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            spi_en,
  output logic                            spi_cpol,
  output logic                            spi_cpha,
  output logic [15:0]                     spi_clkdiv,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   rx_data,
  input  logic                            rx_push,
  input  logic                            spi_busy
);

  localparam int DATA_W = C_S_AXI_DATA_WIDTH;

  logic              aw_held, w_held;
  logic [2:0]        aw_ofs_q;
  logic [DATA_W-1:0] w_data_q;
  logic [3:0]        w_strb_q;
  logic              b_vld;
  logic [1:0]        b_resp;
  logic              aw_hs, w_hs, ar_hs, wr_commit, wr_slverr;

  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic [1:0]        rresp_p1;
  logic [2:0]        ar_ofs;
  logic [DATA_W-1:0] rd_word;
  logic              rd_err, rd_rx_clr;

  logic [DATA_W-1:0] ctrl_q, clkdiv_q, txdata_q, scratch_q, rxdata_q;
  logic              rx_full;
  ctrl_t             ctrl_bits;
  logic              unused_ok;

  // READYs stay low while reset is held so nothing is accepted mid-reset.
  assign S_AXI_AWREADY = ARESETN && !aw_held && !b_vld;
  assign S_AXI_WREADY  = ARESETN && !w_held && !b_vld;
  assign S_AXI_ARREADY = ARESETN && !vld_p1;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_RVALID  = vld_p1;
  assign S_AXI_RDATA   = rdata_p1;
  assign S_AXI_RRESP   = rresp_p1;

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign wr_commit = aw_held && w_held;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      b_vld   <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (wr_commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_vld   <= 1'b1;
        b_resp  <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
      end else if (b_vld && S_AXI_BREADY) begin
        b_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_ofs_q <= S_AXI_AWADDR[4:2];
    if (w_hs) begin
      w_data_q <= S_AXI_WDATA;
      w_strb_q <= S_AXI_WSTRB;
    end
  end

  assign ar_ofs    = S_AXI_ARADDR[4:2];
  assign rd_rx_clr = ar_hs && (ar_ofs == OFS_RXDATA);

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (ar_ofs)
      OFS_CTRL:    rd_word = ctrl_q;
      OFS_CLKDIV:  rd_word = clkdiv_q;
      OFS_TXDATA:  rd_word = txdata_q;
      OFS_SCRATCH: rd_word = scratch_q;
      OFS_STATUS:  rd_word = {{(DATA_W-3){1'b0}}, tx_valid, rx_full, spi_busy};
      OFS_RXDATA:  rd_word = rxdata_q;
      default:     rd_err  = 1'b1;
    endcase
  end

  // Read stage p1: registered data/response one cycle after the AR handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      rresp_p1 <= RESP_OKAY;
    end else if (ar_hs) begin
      vld_p1   <= 1'b1;
      rdata_p1 <= rd_word;
      rresp_p1 <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (vld_p1 && S_AXI_RREADY) begin
      vld_p1 <= 1'b0;
    end
  end

  spi_ctrl_regbank #(
    .DATA_W       (DATA_W),
    .CLKDIV_RESET (CLKDIV_RESET)
  ) u_regbank (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .wr_en      (wr_commit),
    .wr_ofs     (aw_ofs_q),
    .wr_data    (w_data_q),
    .wr_strb    (w_strb_q),
    .wr_slverr  (wr_slverr),
    .rd_rx_clr  (rd_rx_clr),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .rx_data_in (rx_data),
    .rx_push    (rx_push),
    .ctrl_q     (ctrl_q),
    .clkdiv_q   (clkdiv_q),
    .txdata_q   (txdata_q),
    .scratch_q  (scratch_q),
    .rxdata_q   (rxdata_q),
    .rx_full    (rx_full)
  );

  assign ctrl_bits  = ctrl_t'(ctrl_q[2:0]);
  assign spi_en     = ctrl_bits.en;
  assign spi_cpol   = ctrl_bits.cpol;
  assign spi_cpha   = ctrl_bits.cpha;
  assign spi_clkdiv = clkdiv_q[15:0];
  assign tx_data    = txdata_q;

  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_spi_ctrl_axil_slave.sv
// Directed bench for spi_ctrl_axil_slave with hand-computed expected values.
module tb_spi_ctrl_axil_slave;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        spi_en, spi_cpol, spi_cpha;
  logic [15:0] spi_clkdiv;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_push, spi_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_ctrl_axil_slave dut (
    .ACLK(clk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .spi_en(spi_en), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_clkdiv(spi_clkdiv),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_push(rx_push), .spi_busy(spi_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, output logic [1:0] resp);
    logic aw_go, w_go;
    int   n;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      tick();
      n++;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
    end
    chk("wr_accept", {31'd0, awvalid | wvalid}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    chk("wr_bvalid", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic go;
    int   n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1; n = 0;
    while (arvalid && n < 20) begin
      go = arready;
      tick();
      n++;
      if (go) arvalid = 1'b0;
    end
    chk("rd_accept", {31'd0, arvalid}, 32'd0);
    arvalid = 1'b0;
    chk("rd_latency", {31'd0, rvalid}, 32'd1);
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    data = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_resp"}, {30'd0, r}, {30'd0, exp_resp});
  endtask

  task automatic wr_chk(input string tag, input logic [4:0] addr, input logic [31:0] data,
                        input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, data, r);
    chk({tag, "_bresp"}, {30'd0, r}, {30'd0, exp_resp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = 4'hF; tx_ready = 1'b0; rx_data = '0; rx_push = 1'b0; spi_busy = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    chk("rst_bresp",   {30'd0, bresp}, 32'd0);
    chk("rst_txvalid", {31'd0, tx_valid}, 32'd0);
    chk("rst_clkdiv",  {16'd0, spi_clkdiv}, 32'd4);
    chk("rst_en",      {31'd0, spi_en}, 32'd0);
    aresetn = 1'b1;
    tick();
    chk("post_rst_awready", {31'd0, awready}, 32'd1);

    // Basic RW registers
    wr_chk("w_ctrl", 5'h00, 32'h1, 2'b00);
    wr_chk("w_clkdiv", 5'h04, 32'h2, 2'b00);
    wr_chk("w_tx", 5'h08, 32'h3, 2'b00);
    wr_chk("w_scr", 5'h0C, 32'h4, 2'b00);
    rd_chk("r_ctrl", 5'h00, 32'h1, 2'b00);
    rd_chk("r_clkdiv", 5'h04, 32'h2, 2'b00);
    rd_chk("r_tx", 5'h08, 32'h3, 2'b00);
    rd_chk("r_scr", 5'h0C, 32'h4, 2'b00);
    chk("spi_en", {31'd0, spi_en}, 32'd1);
    chk("spi_clkdiv", {16'd0, spi_clkdiv}, 32'h2);
    chk("tx_launch1", {31'd0, tx_valid}, 32'd1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_drain1", {31'd0, tx_valid}, 32'd0);
    rd_chk("r_addr_lsb", 5'h07, 32'h2, 2'b00);
    wr_chk("w_ctrl6", 5'h00, 32'h6, 2'b00);
    chk("ctrl6_en",   {31'd0, spi_en},   32'd0);
    chk("ctrl6_cpol", {31'd0, spi_cpol}, 32'd1);
    chk("ctrl6_cpha", {31'd0, spi_cpha}, 32'd1);

    // AW three cycles ahead of W, BREADY held low
    bready = 1'b0;
    awaddr = 5'h0C; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b0;
    chk("dec_awready", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("dec_aw_block", {31'd0, awready}, 32'd0);
      tick();
    end
    wvalid = 1'b1;
    chk("dec_wready", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0;
    chk("dec_b_early", {31'd0, bvalid}, 32'd0);
    tick();
    chk("dec_b_rise", {31'd0, bvalid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dec_b_hold", {29'd0, bvalid, bresp}, 32'h4);
      chk("dec_aw_busy", {31'd0, awready}, 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("dec_b_drop", {31'd0, bvalid}, 32'd0);
    tick();
    chk("dec_b_once", {31'd0, bvalid}, 32'd0);
    rd_chk("dec_scr", 5'h0C, 32'h55, 2'b00);

    // Same-cycle AW+W: BVALID two cycles after the handshake cycle
    awaddr = 5'h0C; wdata = 32'h66; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("lat_b_n1", {31'd0, bvalid}, 32'd0);
    tick();
    chk("lat_b_n2", {31'd0, bvalid}, 32'd1);
    chk("lat_wready_blk", {31'd0, wready}, 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    rd_chk("lat_scr", 5'h0C, 32'h66, 2'b00);

    // TX handshake and busy-TXDATA rejection
    wr_chk("tx_first", 5'h08, 32'hA5A5_0001, 2'b00);
    chk("tx_valid_set", {31'd0, tx_valid}, 32'd1);
    chk("tx_data_1", tx_data, 32'hA5A5_0001);
    wr_chk("tx_second", 5'h08, 32'h1234_5678, 2'b10);
    chk("tx_data_kept", tx_data, 32'hA5A5_0001);
    chk("tx_valid_kept", {31'd0, tx_valid}, 32'd1);
    rd_chk("tx_rd_busy", 5'h08, 32'hA5A5_0001, 2'b00);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_valid_clr", {31'd0, tx_valid}, 32'd0);
    rd_chk("tx_rd_after", 5'h08, 32'hA5A5_0001, 2'b00);

    // RX capture and sticky flag
    rx_data = 32'hDEAD_BEEF; rx_push = 1'b1;
    tick();
    rx_push = 1'b0;
    rd_chk("rx_stat_full", 5'h10, 32'h2, 2'b00);
    rd_chk("rx_data", 5'h14, 32'hDEAD_BEEF, 2'b00);
    rd_chk("rx_stat_clr", 5'h10, 32'h0, 2'b00);
    rx_data = 32'h1111_1111; rx_push = 1'b1;
    tick();
    rx_push = 1'b0;
    araddr = 5'h14; arvalid = 1'b1; rready = 1'b0;
    rx_data = 32'h2222_2222; rx_push = 1'b1;
    tick();
    arvalid = 1'b0; rx_push = 1'b0;
    chk("rxc_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rxc_old_word", rdata, 32'h1111_1111);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    rd_chk("rxc_stat", 5'h10, 32'h2, 2'b00);
    rd_chk("rxc_new_word", 5'h14, 32'h2222_2222, 2'b00);
    spi_busy = 1'b1;
    rd_chk("stat_busy", 5'h10, 32'h1, 2'b00);
    spi_busy = 1'b0;

    // Unmapped and read-only offsets
    rd_chk("unm_rd", 5'h18, 32'h0, 2'b10);
    wr_chk("unm_wr", 5'h1C, 32'hFFFF_FFFF, 2'b10);
    rd_chk("unm_scr", 5'h0C, 32'h66, 2'b00);
    rd_chk("unm_ctrl", 5'h00, 32'h6, 2'b00);
    wr_chk("ro_stat_wr", 5'h10, 32'hFFFF_FFFF, 2'b00);
    rd_chk("ro_stat", 5'h10, 32'h0, 2'b00);
    wr_chk("ro_rx_wr", 5'h14, 32'h0BAD_0BAD, 2'b00);
    rd_chk("ro_rx", 5'h14, 32'h2222_2222, 2'b00);

    // Reset with both responses pending
    bready = 1'b0; rready = 1'b0;
    awaddr = 5'h0C; wdata = 32'h77; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    chk("mid_bvalid", {31'd0, bvalid}, 32'd1);
    chk("mid_rvalid", {31'd0, rvalid}, 32'd1);
    aresetn = 1'b0;
    tick();
    chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    aresetn = 1'b1;
    bready = 1'b1; rready = 1'b1;
    tick();
    chk("mid_no_bresp", {31'd0, bvalid}, 32'd0);
    chk("mid_no_rresp", {31'd0, rvalid}, 32'd0);
    bready = 1'b0; rready = 1'b0;
    rd_chk("mid_clkdiv", 5'h04, 32'h4, 2'b00);
    rd_chk("mid_scr", 5'h0C, 32'h0, 2'b00);
    rd_chk("mid_ctrl", 5'h00, 32'h0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
